// File: rtl/biss_c_pkg.sv
// Shared BiSS-C definitions: frame state encoding, CRC6 constants and field lengths.
// Used by the slave transmitter and the master receiver.
package biss_c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_START,
        ST_CDS,
        ST_DATA,
        ST_ERRW,
        ST_CRC,
        ST_TIMEOUT
    } biss_state_t;

    localparam int CRC_W = 6;
    // Taps below x^6 for x^6 + x + 1
    localparam logic [CRC_W-1:0] CRC_POLY = 6'h03;

    localparam int START_LEN = 1;
    localparam int CDS_LEN   = 1;
    localparam int ERR_LEN   = 1;
    localparam int WARN_LEN  = 1;

endpackage

// File: rtl/biss_crc6_serial.sv
// Serial CRC6 LFSR, MSB-first, with synchronous clear and per-bit enable.
module biss_crc6_serial
    import biss_c_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic inv;

    assign inv = din ^ crc[CRC_W-1];

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (inv ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/biss_c_slave_tx.sv
// BiSS-C slave frame transmitter: answers MA with ack, start, CDS, position, nE, nW, ~CRC6.
// Define BISS_MA_SYNC_EN to pass MA through a 2-FF synchronizer (3 CLK MA-to-SLO latency).
module biss_c_slave_tx
    import biss_c_pkg::*;
#(
    parameter int DATA_W      = 26,
    parameter int ACK_LEN     = 1,
    parameter int TIMEOUT_CYC = 2000
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              MA,
    input  logic [DATA_W-1:0] POS,
    input  logic              NERR,
    input  logic              NWARN,
    output logic              SLO,
    output logic              BUSY,
    output logic              LATCH,
    output logic              FRAME_DONE
);

    localparam int CNT_W = $clog2(DATA_W + ACK_LEN + CRC_W + START_LEN + CDS_LEN
                                  + ERR_LEN + WARN_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    biss_state_t       state;
    logic              ma_s;
    logic              ma_d;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] pos_q;
    logic              nerr_q;
    logic              nwarn_q;
    logic              aborted;
    logic              crc_clr;
    logic              crc_en;
    logic              crc_din;
    logic [CRC_W-1:0]  crc;
    logic [2:0]        crc_idx;

`ifdef BISS_MA_SYNC_EN
    logic [1:0] ma_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ma_sync <= 2'b11;
        end else begin
            ma_sync <= {ma_sync[0], MA};
        end
    end

    assign ma_s = ma_sync[1];
`else
    assign ma_s = MA;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            ma_d <= 1'b1;
        end else begin
            ma_d <= ma_s;
        end
    end

    assign fall    = ma_d & ~ma_s;
    assign rise    = ~ma_d & ma_s;
    assign crc_clr = (state == ST_IDLE) && fall;
    assign crc_idx = 3'(CRC_W - 1) - bit_cnt[2:0];

    // The CRC advances on exactly the position, nE and nW bits as they leave on SLO
    always_comb begin
        crc_en  = 1'b0;
        crc_din = 1'b0;
        if (rise && state == ST_DATA) begin
            crc_en  = 1'b1;
            crc_din = pos_q[DATA_W-1];
        end else if (rise && state == ST_ERRW) begin
            crc_en  = 1'b1;
            crc_din = (bit_cnt == '0) ? nerr_q : nwarn_q;
        end
    end

    biss_crc6_serial u_crc (
        .CLK (CLK),
        .RST (RST),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            SLO        <= 1'b1;
            BUSY       <= 1'b0;
            LATCH      <= 1'b0;
            FRAME_DONE <= 1'b0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            pos_q      <= '0;
            nerr_q     <= 1'b0;
            nwarn_q    <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            LATCH      <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SLO    <= 1'b1;
                    BUSY   <= 1'b0;
                    to_cnt <= '0;
                    if (fall) begin
                        pos_q   <= POS;
                        nerr_q  <= NERR;
                        nwarn_q <= NWARN;
                        LATCH   <= 1'b1;
                        BUSY    <= 1'b1;
                        bit_cnt <= '0;
                        aborted <= 1'b0;
                        state   <= ST_ACK;
                    end
                end
                ST_TIMEOUT: begin
                    if (rise || fall || !ma_s) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        SLO        <= 1'b1;
                        BUSY       <= 1'b0;
                        FRAME_DONE <= ~aborted;
                        to_cnt     <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    // Frame fields advance on MA rises only; falls merely restart the watchdog
                    if (rise) begin
                        to_cnt <= '0;
                        case (state)
                            ST_ACK: begin
                                SLO <= 1'b0;
                                if (bit_cnt == CNT_W'(ACK_LEN - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= ST_START;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_START: begin
                                SLO   <= 1'b1;
                                state <= ST_CDS;
                            end
                            ST_CDS: begin
                                SLO     <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_DATA;
                            end
                            ST_DATA: begin
                                SLO   <= pos_q[DATA_W-1];
                                pos_q <= {pos_q[DATA_W-2:0], 1'b0};
                                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= ST_ERRW;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_ERRW: begin
                                if (bit_cnt == '0) begin
                                    SLO     <= nerr_q;
                                    bit_cnt <= bit_cnt + 1'b1;
                                end else begin
                                    SLO     <= nwarn_q;
                                    bit_cnt <= '0;
                                    state   <= ST_CRC;
                                end
                            end
                            ST_CRC: begin
                                if (bit_cnt == CNT_W'(CRC_W)) begin
                                    SLO     <= 1'b0;
                                    bit_cnt <= '0;
                                    state   <= ST_TIMEOUT;
                                end else begin
                                    SLO     <= ~crc[crc_idx];
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (fall || !ma_s) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        SLO     <= 1'b0;
                        aborted <= 1'b1;
                        to_cnt  <= '0;
                        state   <= ST_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biss_c_slave_tx.sv
// Scoreboard bench for biss_c_slave_tx: driver queues expected SLO bits, monitor checks them.
// Reference frame and CRC are built from the BiSS-C field layout with polynomial division.
module tb_biss_c_slave_tx;

    localparam int DATA_W      = 26;
    localparam int ACK_LEN     = 1;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 5;
    localparam int FRAME_LEN   = ACK_LEN + 2 + DATA_W + 2 + 6 + 1;
`ifdef BISS_MA_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              CLK   = 1'b0;
    logic              RST   = 1'b1;
    logic              MA    = 1'b1;
    logic [DATA_W-1:0] POS   = '0;
    logic              NERR  = 1'b1;
    logic              NWARN = 1'b1;
    logic              SLO;
    logic              BUSY;
    logic              LATCH;
    logic              FRAME_DONE;

    int vectorCount = 0;
    int missCount   = 0;
    int doneCount   = 0;
    int latchCount  = 0;
    bit expQ[$];
    bit frameBits[$];

    biss_c_slave_tx #(
        .DATA_W      (DATA_W),
        .ACK_LEN     (ACK_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MA         (MA),
        .POS        (POS),
        .NERR       (NERR),
        .NWARN      (NWARN),
        .SLO        (SLO),
        .BUSY       (BUSY),
        .LATCH      (LATCH),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Pulse counters sampled away from the active edge
    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) doneCount++;
        if (LATCH === 1'b1) latchCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // CRC = remainder of (message * x^6) divided by x^6 + x + 1
    function automatic logic [5:0] refCrc(input logic [DATA_W-1:0] pos, input logic nerr, input logic nwarn);
        logic [63:0] v;
        v = 64'({pos, nerr, nwarn}) << 6;
        for (int i = DATA_W + 2 + 5; i >= 6; i--) begin
            if (v[i]) v = v ^ (64'h43 << (i - 6));
        end
        return v[5:0];
    endfunction

    function automatic void buildFrame(input logic [DATA_W-1:0] pos, input logic nerr, input logic nwarn);
        logic [5:0] c;
        c = refCrc(pos, nerr, nwarn);
        frameBits.delete();
        for (int i = 0; i < ACK_LEN; i++) frameBits.push_back(1'b0);
        frameBits.push_back(1'b1);
        frameBits.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) frameBits.push_back(pos[i]);
        frameBits.push_back(nerr);
        frameBits.push_back(nwarn);
        for (int i = 5; i >= 0; i--) frameBits.push_back(~c[i]);
        frameBits.push_back(1'b0);
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Starts a frame with one MA fall, then issues nRises MA rises; returns right after the last rise
    task automatic applyStimulus(input logic [DATA_W-1:0] pos, input logic nerr, input logic nwarn,
                                 input int nRises);
        int cycles;
        POS   = pos;
        NERR  = nerr;
        NWARN = nwarn;
        buildFrame(pos, nerr, nwarn);
        MA     = 1'b0;
        cycles = 0;
        do begin
            waitCycles(1);
            cycles++;
        end while (LATCH !== 1'b1 && cycles < HALF);
        checkOutput("ma_to_latch_latency", cycles, LAT);
        POS   = DATA_W'($urandom());
        NERR  = ~nerr;
        NWARN = ~nwarn;
        waitCycles(HALF - cycles);
        for (int i = 0; i < nRises; i++) begin
            expQ.push_back(frameBits[i]);
            MA = 1'b1;
            if (i < nRises - 1) begin
                waitCycles(HALF);
                MA = 1'b0;
                waitCycles(HALF);
            end
        end
    endtask

    task automatic finishFrame();
        int cycles;
        cycles = 0;
        while (FRAME_DONE !== 1'b1 && cycles < LAT + TIMEOUT_CYC + 20) begin
            waitCycles(1);
            cycles++;
        end
        checkOutput("frame_done_delay", cycles, LAT + TIMEOUT_CYC);
        checkOutput("slo_back_idle", SLO, 1);
        checkOutput("busy_clear_at_done", BUSY, 0);
        waitCycles(20);
    endtask

    task automatic runRandomFrame();
        applyStimulus(DATA_W'($urandom()), 1'($urandom()), 1'($urandom()), FRAME_LEN);
        finishFrame();
    endtask

    // Monitor: each MA rise presents one SLO bit once the pipeline latency has elapsed
    initial begin
        forever begin
            @(posedge MA);
            repeat (LAT + 1) @(negedge CLK);
            if (expQ.size() > 0) begin
                bit e;
                e = expQ.pop_front();
                checkOutput("slo_bit", SLO, e);
            end
        end
    end

    initial begin
        int bad;
        int cycles;
        int doneBefore;
        logic sloMid;
        logic busyMid;

        RST = 1'b1;
        waitCycles(3);
        checkOutput("reset_slo", SLO, 1);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_latch", LATCH, 0);
        checkOutput("reset_frame_done", FRAME_DONE, 0);
        RST = 1'b0;
        waitCycles(2);

        $display("[TB] idle check");
        bad = 0;
        repeat (10000) begin
            waitCycles(1);
            if (SLO !== 1'b1 || BUSY !== 1'b0 || LATCH !== 1'b0 || FRAME_DONE !== 1'b0) bad++;
        end
        checkOutput("idle_bad_cycles", bad, 0);

        $display("[TB] zero-position frame");
        applyStimulus('0, 1'b1, 1'b1, FRAME_LEN);
        finishFrame();

        $display("[TB] random frames");
        repeat (4) runRandomFrame();

        $display("[TB] MA stall abort");
        doneBefore = doneCount;
        applyStimulus(DATA_W'($urandom()), 1'($urandom()), 1'($urandom()), 10);
        cycles  = 0;
        sloMid  = 1'b1;
        busyMid = 1'b0;
        while (BUSY !== 1'b0 && cycles < LAT + 2 * TIMEOUT_CYC + 20) begin
            waitCycles(1);
            cycles++;
            if (cycles == LAT + TIMEOUT_CYC + 5) begin
                sloMid  = SLO;
                busyMid = BUSY;
            end
        end
        checkOutput("abort_idle_delay", cycles, LAT + 2 * TIMEOUT_CYC);
        checkOutput("abort_slo_low", sloMid, 0);
        checkOutput("abort_busy_held", busyMid, 1);
        checkOutput("abort_slo_idle", SLO, 1);
        checkOutput("abort_no_frame_done", doneCount, doneBefore);
        waitCycles(20);

        $display("[TB] reset mid-DATA");
        applyStimulus(DATA_W'($urandom()), 1'($urandom()), 1'($urandom()), 8);
        waitCycles(HALF);
        RST = 1'b1;
        waitCycles(1);
        checkOutput("midreset_slo", SLO, 1);
        checkOutput("midreset_busy", BUSY, 0);
        RST = 1'b0;
        waitCycles(5);
        runRandomFrame();

        checkOutput("scoreboard_drained", expQ.size(), 0);
        checkOutput("frame_done_total", doneCount, 6);
        checkOutput("latch_total", latchCount, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
